cfg_word_loader: RTL and testbench
==================================

// Module: cfg_word_loader
// PURPOSE
//  Writer side of the block-style config interface (config_in / comb_set) used by fabric slices.
//  Accepts the bitstream as a valid/ready stream of CHUNK_W-bit beats, assembles one CONFIG_WIDTH word.
//  Presents the word on config_out and pulses comb_set for exactly one clk so downstream slices latch it.
//  Sits between the chip-level bitstream source and one group of config-consuming tiles.
// PARAMETERS
//  CONFIG_WIDTH  64  bits in the assembled config word; must be a multiple of CHUNK_W (elaboration error otherwise)
//  CHUNK_W       1   bits per stream beat
// PORTS
//  clk           in   1             single clock; all logic on posedge
//  rst           in   1             synchronous, active-high reset
//  cfg_start     in   1             begin a load; honoured only in IDLE or DONE
//  cfg_in_data   in   CHUNK_W       stream beat payload
//  cfg_in_valid  in   1             beat valid
//  cfg_in_ready  out  1             beat accepted on clk edge when valid & ready
//  config_out    out  CONFIG_WIDTH  assembled word; drives slices' config_in
//  comb_set      out  1             one-cycle commit strobe to slices
//  busy          out  1             high in SHIFT/COMMIT (and PARITY when enabled)
//  done          out  1             high in DONE
//  cfg_error     out  1             parity failure; tied 0 without CFG_LOADER_PARITY_EN
// BEHAVIOUR
//  Reset: state=IDLE, config_out=0, beat count=0, comb_set=0, cfg_in_ready=0, busy=0, done=0, cfg_error=0.
//  Reset does not reach slices; their previously committed config persists.
//  NUM_BEATS = CONFIG_WIDTH/CHUNK_W; beat counter width $clog2(NUM_BEATS+1).
//  IDLE: ready=0; valid ignored. cfg_start -> SHIFT, count=0, cfg_error=0.
//  SHIFT: ready=1. Accepted beat: config_out <= {config_out[CONFIG_WIDTH-CHUNK_W-1:0], cfg_in_data}
//    (first beat ends in MSBs). Idle cycles (valid=0) change nothing. cfg_start ignored.
//    Accepting beat NUM_BEATS-1 (0-based) -> COMMIT (or PARITY when enabled).
//  COMMIT: ready=0, comb_set=1 for this single cycle, config_out stable -> DONE.
//    comb_set therefore rises the cycle after the accept edge of the final data beat.
//  DONE: done=1, config_out held. cfg_start -> SHIFT (new load, count=0, done drops next cycle).
//  config_out never changes while comb_set=1; comb_set never asserted outside COMMIT.
//  rst in any state (incl. mid-SHIFT) wins: immediate return to reset values, no comb_set.
// CONFIGURATION
//  CFG_LOADER_PARITY_EN defined: after last data beat enter PARITY (ready=1); one extra beat, bit0 is
//    even parity (= XOR of all CONFIG_WIDTH data bits), upper bits ignored. Running parity kept in SHIFT.
//    Match -> COMMIT. Mismatch -> ERROR: ready=0, cfg_error=1, no comb_set; cfg_start -> SHIFT, clears error.
//  Undefined: no PARITY/ERROR states, no parity register, cfg_error tied 0, SHIFT goes straight to COMMIT.
// STRUCTURE
//  Shared package fpga250_cfg_pkg: state encoding (IDLE, SHIFT, PARITY, COMMIT, DONE, ERROR) and
//    beat-count width helper; reused by future readback/loader blocks.
//  Sub-module cfg_shift_reg (parallel-load-free shift register + running parity); FSM and counter stay in top.
// TESTING (CONFIG_WIDTH=8, CHUNK_W=2 unless noted)
//  1 rst held 3 cycles mid-stream -> all outputs 0, state IDLE, ready=0.
//  2 start; beats 2'b10,2'b10,2'b01,2'b01 back-to-back -> config_out=8'hA5, comb_set high exactly 1 cycle
//    on the cycle after 4th accept, then done=1, busy=0.
//  3 same beats with valid low 1-3 random cycles between -> identical result, no extra/missing shifts.
//  4 valid high in IDLE and DONE with data 2'b11 -> ready=0, config_out unchanged, no comb_set.
//  5 rst after 2 beats, then start + beats for 8'h3C -> no comb_set before reload; final config_out=8'h3C, one pulse.
//  6 PARITY_EN: 8'hA5 + parity beat 2'b00 -> comb_set; 8'hA5 + 2'b01 -> cfg_error=1, no comb_set,
//    next start clears cfg_error.

Source files
------------

// File: rtl/fpga250_cfg_pkg.sv
// Shared config-path definitions: loader state encoding and beat-counter sizing.
// Reused by the loader and future readback blocks.
package fpga250_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } cfg_state_e;

  // Counter must hold NUM_BEATS itself, so size for num_beats+1 values.
  function automatic int unsigned beat_cnt_w(input int unsigned num_beats);
    return (num_beats < 1) ? 1 : $clog2(num_beats + 1);
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Config word shift register: each accepted beat enters at the LSBs, so the first beat ends in the MSBs.
// With CFG_LOADER_PARITY_EN defined, also keeps the running XOR of every shifted-in bit.
module cfg_shift_reg #(
  parameter int unsigned CONFIG_WIDTH = 64,
  parameter int unsigned CHUNK_W      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_i,
  input  logic [CHUNK_W-1:0]      data_i,
`ifdef CFG_LOADER_PARITY_EN
  input  logic                    par_clr_i,
  output logic                    parity_o,
`endif
  output logic [CONFIG_WIDTH-1:0] word_o
);

  logic [CONFIG_WIDTH-1:0] word_q;
  logic [CONFIG_WIDTH-1:0] word_d;

  if (CONFIG_WIDTH > CHUNK_W) begin : g_shift
    assign word_d = {word_q[CONFIG_WIDTH-CHUNK_W-1:0], data_i};
  end else begin : g_load
    assign word_d = CONFIG_WIDTH'(data_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (shift_i) begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

`ifdef CFG_LOADER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (par_clr_i) begin
      par_q <= 1'b0;
    end else if (shift_i) begin
      par_q <= par_q ^ (^data_i);
    end
  end

  assign parity_o = par_q;
`endif

endmodule

// File: rtl/cfg_word_loader.sv
// Writer side of the slice config interface: assembles a config word from a beat stream and strobes comb_set once.
// Optional even-parity check beat enabled by defining CFG_LOADER_PARITY_EN.
module cfg_word_loader
  import fpga250_cfg_pkg::*;
#(
  parameter int unsigned CONFIG_WIDTH = 64,
  parameter int unsigned CHUNK_W      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [CHUNK_W-1:0]      cfg_in_data,
  input  logic                    cfg_in_valid,
  output logic                    cfg_in_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    comb_set,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error
);

  localparam int unsigned NUM_BEATS = CONFIG_WIDTH / CHUNK_W;
  localparam int unsigned CNT_W     = beat_cnt_w(NUM_BEATS);

  if ((CONFIG_WIDTH % CHUNK_W) != 0) begin : g_bad_width
    $error("cfg_word_loader: CONFIG_WIDTH must be a multiple of CHUNK_W");
  end

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             comb_set_q, comb_set_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_en;
  logic             accept;
  logic             last_beat;

  assign accept    = cfg_in_valid & ready_q;
  assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));

`ifdef CFG_LOADER_PARITY_EN
  logic err_q, err_d;
  logic par_clr;
  logic parity;
`endif

  cfg_shift_reg #(
    .CONFIG_WIDTH(CONFIG_WIDTH),
    .CHUNK_W     (CHUNK_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_en),
    .data_i   (cfg_in_data),
`ifdef CFG_LOADER_PARITY_EN
    .par_clr_i(par_clr),
    .parity_o (parity),
`endif
    .word_o   (config_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      comb_set_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      comb_set_q <= comb_set_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_beat) begin
`ifdef CFG_LOADER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_COMMIT;
`endif
          end
        end
      end
`ifdef CFG_LOADER_PARITY_EN
      ST_PARITY: begin
        if (accept) begin
          state_d = (cfg_in_data[0] == parity) ? ST_COMMIT : ST_ERROR;
        end
      end
      ST_ERROR: begin
        if (cfg_start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
`endif
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase

    ready_d    = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
    comb_set_d = (state_d == ST_COMMIT);
    busy_d     = (state_d == ST_SHIFT) || (state_d == ST_PARITY) || (state_d == ST_COMMIT);
    done_d     = (state_d == ST_DONE);
  end

`ifdef CFG_LOADER_PARITY_EN
  assign par_clr = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
  assign err_d   = (state_d == ST_ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_error = err_q;
`else
  assign cfg_error = 1'b0;
`endif

  assign cfg_in_ready = ready_q;
  assign comb_set     = comb_set_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cfg_word_loader.sv
// Bench for cfg_word_loader at CONFIG_WIDTH=8, CHUNK_W=2: vector table plus reset/idle/parity sequences,
// with a scoreboard checking config_out on every comb_set pulse.
module tb_cfg_word_loader;

  localparam int unsigned CW = 8;
  localparam int unsigned BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [BW-1:0] cfg_in_data;
  logic          cfg_in_valid;
  logic          cfg_in_ready;
  logic [CW-1:0] config_out;
  logic          comb_set;
  logic          busy;
  logic          done;
  logic          cfg_error;

  cfg_word_loader #(.CONFIG_WIDTH(CW), .CHUNK_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_in_data (cfg_in_data),
    .cfg_in_valid(cfg_in_valid),
    .cfg_in_ready(cfg_in_ready),
    .config_out  (config_out),
    .comb_set    (comb_set),
    .busy        (busy),
    .done        (done),
    .cfg_error   (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] b0, b1, b2, b3;
    logic [CW-1:0] exp;
    int unsigned   max_gap;
  } vec_t;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  int unsigned   pulses = 0;
  logic [CW-1:0] exp_q[$];
  bit            mon_run = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every commit strobe must match the oldest expected word.
  task automatic monitor();
    logic [CW-1:0] e;
    while (mon_run) begin
      @(negedge clk);
      if (!rst && comb_set) begin
        pulses++;
        check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_config_out", 64'(config_out), 64'(e));
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input int unsigned gap);
    int unsigned waited = 0;
    repeat (gap) begin
      @(negedge clk);
      cfg_in_data = BW'($urandom);
    end
    @(negedge clk);
    cfg_in_data  = d;
    cfg_in_valid = 1'b1;
    while (!cfg_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_in_ready) check("beat_ready_timeout", 64'(cfg_in_ready), 64'd1);
    @(posedge clk);
    #1;
    cfg_in_valid = 1'b0;
  endtask

  // Full load; the model word is pushed only when a commit is expected.
  task automatic load_word(input logic [BW-1:0] b0, b1, b2, b3,
                           input int unsigned max_gap, input logic [BW-1:0] par);
    logic [BW-1:0] bs[4];
    logic [CW-1:0] model;
    bit            commit_ok;
    bs = '{b0, b1, b2, b3};
    model = '0;
    for (int i = 0; i < 4; i++) model = CW'({model, bs[i]});
    commit_ok = 1'b1;
`ifdef CFG_LOADER_PARITY_EN
    commit_ok = (par[0] == ^model);
`endif
    if (commit_ok) exp_q.push_back(model);
    do_start();
    for (int i = 0; i < 4; i++)
      send_beat(bs[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 1));
`ifdef CFG_LOADER_PARITY_EN
    send_beat(par, 0);
`endif
  endtask

  task automatic check_commit(input string name, input logic [CW-1:0] exp, input int unsigned p0);
    @(negedge clk);
    check({name, "_comb_set_hi"}, 64'(comb_set), 64'd1);
    check({name, "_cfg_at_commit"}, 64'(config_out), 64'(exp));
    @(negedge clk);
    check({name, "_comb_set_lo"}, 64'(comb_set), 64'd0);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_ready"}, 64'(cfg_in_ready), 64'd0);
    check({name, "_cfg_held"}, 64'(config_out), 64'(exp));
    check({name, "_pulses"}, 64'(pulses - p0), 64'd1);
  endtask

  task automatic idle_valid(input string name, input logic [CW-1:0] exp_cfg);
    int unsigned p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cfg_in_valid = 1'b1;
      cfg_in_data  = 2'b11;
      @(negedge clk);
      check({name, "_ready"}, 64'(cfg_in_ready), 64'd0);
      check({name, "_cfg"}, 64'(config_out), 64'(exp_cfg));
    end
    cfg_in_valid = 1'b0;
    check({name, "_no_pulse"}, 64'(pulses - p0), 64'd0);
  endtask

  vec_t        vecs[6];
  int unsigned p0;

  initial begin
    vecs[0] = '{b0: 2'b10, b1: 2'b10, b2: 2'b01, b3: 2'b01, exp: 8'hA5, max_gap: 0};
    vecs[1] = '{b0: 2'b10, b1: 2'b10, b2: 2'b01, b3: 2'b01, exp: 8'hA5, max_gap: 3};
    vecs[2] = '{b0: 2'b00, b1: 2'b11, b2: 2'b11, b3: 2'b00, exp: 8'h3C, max_gap: 2};
    vecs[3] = '{b0: 2'b11, b1: 2'b11, b2: 2'b11, b3: 2'b11, exp: 8'hFF, max_gap: 1};
    vecs[4] = '{b0: 2'b00, b1: 2'b00, b2: 2'b00, b3: 2'b00, exp: 8'h00, max_gap: 3};
    vecs[5] = '{b0: 2'b01, b1: 2'b00, b2: 2'b00, b3: 2'b11, exp: 8'h43, max_gap: 0};

    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_in_valid = 1'b0;
    cfg_in_data = '0;

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_config_out", 64'(config_out), 64'd0);
    check("rst_comb_set", 64'(comb_set), 64'd0);
    check("rst_ready", 64'(cfg_in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_error", 64'(cfg_error), 64'd0);
    rst = 1'b0;

    // Reset held 3 cycles in the middle of a load.
    p0 = pulses;
    do_start();
    send_beat(2'b11, 0);
    send_beat(2'b01, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_config_out", 64'(config_out), 64'd0);
      check("midrst_ready", 64'(cfg_in_ready), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", 64'(cfg_in_ready), 64'd0);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_done", 64'(done), 64'd0);
    check("postrst_comb_set", 64'(comb_set), 64'd0);
    check("postrst_no_pulse", 64'(pulses - p0), 64'd0);

    idle_valid("idle_valid", 8'h00);

    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      load_word(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].max_gap,
                {1'b0, ^vecs[i].exp});
      check_commit($sformatf("vec%0d", i), vecs[i].exp, p0);
    end

    idle_valid("done_valid", 8'h43);

    // Reset after two beats, then a clean reload.
    p0 = pulses;
    do_start();
    send_beat(2'b10, 0);
    send_beat(2'b01, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("abort_no_pulse", 64'(pulses - p0), 64'd0);
    check("abort_cfg_cleared", 64'(config_out), 64'd0);
    load_word(2'b00, 2'b11, 2'b11, 2'b00, 0, 2'b00);
    check_commit("reload", 8'h3C, p0);

`ifdef CFG_LOADER_PARITY_EN
    p0 = pulses;
    load_word(2'b10, 2'b10, 2'b01, 2'b01, 0, 2'b00);
    check_commit("par_ok", 8'hA5, p0);
    p0 = pulses;
    load_word(2'b10, 2'b10, 2'b01, 2'b01, 0, 2'b10);
    check_commit("par_upper_ignored", 8'hA5, p0);

    p0 = pulses;
    load_word(2'b10, 2'b10, 2'b01, 2'b01, 0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("par_bad_comb_set", 64'(comb_set), 64'd0);
      check("par_bad_error", 64'(cfg_error), 64'd1);
      check("par_bad_ready", 64'(cfg_in_ready), 64'd0);
      check("par_bad_busy", 64'(busy), 64'd0);
    end
    check("par_bad_no_pulse", 64'(pulses - p0), 64'd0);
    load_word(2'b00, 2'b11, 2'b11, 2'b00, 0, 2'b00);
    check("par_retry_error_clr", 64'(cfg_error), 64'd0);
    check_commit("par_retry", 8'h3C, p0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    mon_run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
